onehot_decoder_seq: RTL and testbench

Parametrised, registered AW-to-2^AW one-hot decoder with enable and two operating modes. In direct mode it decodes addresses accepted over a valid/ready handshake. In scan mode it self-sequences through every output with a programmable dwell time. It is the next generation of the team's fixed-width 2-to-4 / 3-to-8 / 4-to-16 decoder family and serves as the select generator for row/bank strobes and multiplexed display or sensor scanning.

---
 rtl/dec_pkg.sv | 17 +
 rtl/dec_onehot.sv | 16 +
 rtl/onehot_decoder_seq.sv | 144 ++++++++++++++
 tb/tb_onehot_decoder_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared types and constants for the onehot_decoder_seq block.
// States, mode encodings and the legal address-width range.
package dec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int AW_MIN = 1;
  localparam int AW_MAX = 6;

endpackage

// File: rtl/dec_onehot.sv
// Combinational AW-to-2^AW one-hot decoder.
// Output is all zeros when en is low.
module dec_onehot #(
  parameter int AW = 4
) (
  input  logic [AW-1:0]      addr,
  input  logic               en,
  output logic [2**AW-1:0]   y
);

  always_comb begin
    y = '0;
    if (en) y[addr] = 1'b1;
  end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered one-hot decoder with handshake direct mode and dwell scan.
// Scan mode is built only with ONEHOT_DECODER_SEQ_SCAN_EN defined.
module onehot_decoder_seq
  import dec_pkg::*;
#(
  parameter  int AW      = 4,
  parameter  int DWELL_W = 8,
  localparam int OUTS    = 2**AW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [AW-1:0]      in_addr,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUTS-1:0]    y,
  output logic               y_valid,
  output logic [AW-1:0]      cur_addr,
  output logic               wrap
);

  if (AW < AW_MIN || AW > AW_MAX) begin : g_bad_aw
    $error("onehot_decoder_seq: AW out of range");
  end

  state_t          state, state_d;
  logic [AW-1:0]   addr_d;
  logic            act_d;
  logic            wrap_d;
  logic [OUTS-1:0] y_d;
  logic            scan_m;
  logic            hs;

`ifdef ONEHOT_DECODER_SEQ_SCAN_EN
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  assign scan_m = (mode == MODE_SCAN);
`else
  logic unused_scan;
  assign unused_scan = ^{mode, dwell};
  assign scan_m = 1'b0;
`endif

  assign in_ready = en & ~scan_m;
  assign hs       = in_valid & in_ready;

  always_comb begin
    state_d = state;
    addr_d  = cur_addr;
    act_d   = y_valid;
    wrap_d  = 1'b0;
`ifdef ONEHOT_DECODER_SEQ_SCAN_EN
    cnt_d   = cnt_q;
`endif
    if (!en) begin
      state_d = IDLE;
      addr_d  = '0;
      act_d   = 1'b0;
`ifdef ONEHOT_DECODER_SEQ_SCAN_EN
      cnt_d   = '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          addr_d = '0;
          act_d  = 1'b0;
          if (scan_m) begin
            state_d = SCAN;
            act_d   = 1'b1;
`ifdef ONEHOT_DECODER_SEQ_SCAN_EN
            cnt_d   = '0;
`endif
          end else if (hs) begin
            state_d = HOLD;
            addr_d  = in_addr;
            act_d   = 1'b1;
          end
        end
        HOLD: begin
          if (scan_m) begin
            // Mode change: one idle cycle, handshake not taken.
            state_d = IDLE;
            addr_d  = '0;
            act_d   = 1'b0;
          end else if (hs) begin
            addr_d  = in_addr;
          end
        end
`ifdef ONEHOT_DECODER_SEQ_SCAN_EN
        SCAN: begin
          if (!scan_m) begin
            state_d = IDLE;
            addr_d  = '0;
            act_d   = 1'b0;
            cnt_d   = '0;
          end else if (cnt_q >= dwell) begin
            addr_d  = cur_addr + 1'b1;
            cnt_d   = '0;
            wrap_d  = &cur_addr;
          end else begin
            cnt_d   = cnt_q + 1'b1;
          end
        end
`endif
        default: begin
          state_d = IDLE;
          addr_d  = '0;
          act_d   = 1'b0;
        end
      endcase
    end
  end

  dec_onehot #(.AW(AW)) u_dec (
    .addr (addr_d),
    .en   (act_d),
    .y    (y_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      y        <= '0;
      y_valid  <= 1'b0;
      cur_addr <= '0;
      wrap     <= 1'b0;
    end else begin
      state    <= state_d;
      y        <= y_d;
      y_valid  <= act_d;
      cur_addr <= addr_d;
      wrap     <= wrap_d;
    end
  end

`ifdef ONEHOT_DECODER_SEQ_SCAN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed bench for onehot_decoder_seq (direct path always,
// scan path when ONEHOT_DECODER_SEQ_SCAN_EN is defined).
module tb_onehot_decoder_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, mode, in_valid, in_ready;
  logic [3:0]  in_addr;
  logic [7:0]  dwell;
  logic [15:0] y;
  logic        y_valid, wrap;
  logic [3:0]  cur_addr;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  onehot_decoder_seq #(.AW(4), .DWELL_W(8)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .dwell    (dwell),
    .y        (y),
    .y_valid  (y_valid),
    .cur_addr (cur_addr),
    .wrap     (wrap)
  );

`ifdef ONEHOT_DECODER_SEQ_SCAN_EN
  logic       en2, mode2, iv2, ir2, yv2, wrap2;
  logic [1:0] ia2, ca2;
  logic [7:0] dw2;
  logic [3:0] y2;

  onehot_decoder_seq #(.AW(2), .DWELL_W(8)) u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en2),
    .mode     (mode2),
    .in_valid (iv2),
    .in_ready (ir2),
    .in_addr  (ia2),
    .dwell    (dw2),
    .y        (y2),
    .y_valid  (yv2),
    .cur_addr (ca2),
    .wrap     (wrap2)
  );
`endif

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    mode     = 1'b0;
    in_valid = 1'b0;
    in_addr  = '0;
    dwell    = 8'd0;
`ifdef ONEHOT_DECODER_SEQ_SCAN_EN
    en2 = 1'b0; mode2 = 1'b1; iv2 = 1'b0;
    ia2 = '0;   dw2 = 8'd2;
`endif
    #12;
    check("rst_y",    y,        0);
    check("rst_yv",   y_valid,  0);
    check("rst_cur",  cur_addr, 0);
    check("rst_wrap", wrap,     0);
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_y", y, 0);

    en = 1'b1;
    #1;
    check("rdy_en", in_ready, 1);
    in_valid = 1'b1;
    in_addr  = 4'd9;
    tick();
    check("d9_y",   y,        16'h0200);
    check("d9_cur", cur_addr, 9);
    check("d9_yv",  y_valid,  1);
    in_addr = 4'd0;
    tick();
    check("d0_y",   y,        16'h0001);
    check("d0_cur", cur_addr, 0);
    check("d0_yv",  y_valid,  1);
    in_addr = 4'd15;
    tick();
    check("d15_y",   y,        16'h8000);
    check("d15_cur", cur_addr, 15);
    in_valid = 1'b0;
    in_addr  = 4'd2;
    tick();
    check("hold_y",    y,    16'h8000);
    check("hold_wrap", wrap, 0);

    en       = 1'b0;
    in_valid = 1'b1;
    in_addr  = 4'd3;
    #1;
    check("rdy_dis", in_ready, 0);
    tick();
    check("dis_y",   y,        0);
    check("dis_yv",  y_valid,  0);
    check("dis_cur", cur_addr, 0);
    tick();
    check("dis_y2", y, 0);
    en = 1'b1;
    tick();
    check("d3_y",   y,        16'h0008);
    check("d3_cur", cur_addr, 3);

    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("arst_y",   y,        0);
    check("arst_yv",  y_valid,  0);
    check("arst_cur", cur_addr, 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("post_y",  y,       0);
    check("post_yv", y_valid, 0);

`ifndef ONEHOT_DECODER_SEQ_SCAN_EN
    mode = 1'b1;
    dwell = 8'd1;
    #1;
    check("m1_rdy", in_ready, 1);
    tick();
    check("m1_idle", y, 0);
    in_valid = 1'b1;
    in_addr  = 4'd5;
    tick();
    check("m1_y",    y,        16'h0020);
    check("m1_cur",  cur_addr, 5);
    check("m1_wrap", wrap,     0);
    in_addr = 4'd12;
    tick();
    check("m1_y12",  y,    16'h1000);
    check("m1_wrp2", wrap, 0);
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("m1_hold", y,    16'h1000);
      check("m1_nwrp", wrap, 0);
    end
`else
    en2 = 1'b1;
    for (int k = 0; k < 24; k++) begin
      tick();
      check("scan_y",    y2,    4'b0001 << ((k / 3) % 4));
      check("scan_cur",  ca2,   (k / 3) % 4);
      check("scan_wrap", wrap2, (k > 0 && k % 12 == 0));
    end
    for (int k = 24; k <= 30; k++) tick();
    check("sw_at2", y2, 4'b0100);
    mode2 = 1'b0;
    iv2   = 1'b1;
    ia2   = 2'd1;
    tick();
    check("sw_gap",  y2,  0);
    check("sw_gapv", yv2, 0);
    tick();
    check("sw_d1",   y2,  4'b0010);
    check("sw_c1",   ca2, 1);
    iv2   = 1'b0;
    mode2 = 1'b1;
    tick();
    check("sw2_gap", y2, 0);
    tick();
    check("sw2_s0",  y2, 4'b0001);
    rst_n = 1'b0;
    #1;
    check("sarst_y",  y2,  0);
    check("sarst_c",  ca2, 0);
    check("sarst_yv", yv2, 0);
    tick();
    rst_n = 1'b1;
    en2   = 1'b0;
    tick();
    check("sidle_y", y2, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
